div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 Start  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  32  signed dividend (two's complement).
REQ-006 B  input  32  signed divisor (two's complement).
REQ-007 HI  output  32  remainder register; feeds the register-file write-data select mux.
REQ-008 LO  output  32  quotient register; feeds the register-file write-data select mux.
REQ-009 Busy  output  1  high while a division is in progress (CALC or FIX).
REQ-010 Done  output  1  one-cycle pulse on completion.
REQ-011 DivZero  output  1  one-cycle pulse when Start is accepted with B == 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, FIX.
REQ-013 IDLE, Start=1, B!=0 at edge E0: latch |A|, |B|, sign(A) and sign(A) xor sign(B); clear the partial remainder; load the iteration counter with 31; go to CALC.
REQ-014 IDLE, Start=1, B==0 at edge E0: stay in IDLE; DivZero=1 for the cycle after E0; leave HI and LO unchanged; keep Done=0.
REQ-015 CALC: perform one restoring shift-subtract iteration per cycle (unsigned, 33-bit partial remainder) on edges E1..E32; decrement the counter each edge; go to FIX at E32 (counter == 0).
REQ-016 FIX at E33: LO = quotient, negated when the signs differ; HI = remainder, negated when A is negative; Done=1 for the cycle after E33; go to IDLE.
REQ-017 Latency SHALL be fixed: HI and LO valid and Done high in the cycle following E33, independent of operand values.
REQ-018 Busy SHALL be 1 in CALC and FIX and 0 in IDLE; Busy SHALL fall on the same edge that raises Done.
REQ-019 Start SHALL be ignored while Busy=1; latched operands SHALL NOT change mid-operation.
REQ-020 A, B changes after E0 SHALL NOT affect the result.
REQ-021 Quotient magnitude SHALL satisfy |A| = |Q|*|B| + |R| with |R| < |B|, computed unsigned on 32-bit magnitudes.
REQ-022 A=0x80000000, B=0xFFFFFFFF: |A| is taken as unsigned 0x80000000; the result SHALL be LO=0x80000000, HI=0x00000000, Done asserted, and no error flag raised.
REQ-023 HI and LO SHALL hold their last value until the next completed division (FIX) or reset.
REQ-024 Start in the IDLE cycle directly after Done SHALL be accepted (back-to-back operation).
REQ-025 Done and DivZero SHALL never be high in the same cycle.

Reset
REQ-026 While reset_n=0, irrespective of clk: state=IDLE, HI=0, LO=0, Busy=0, Done=0, DivZero=0, counter=0, all internal operand registers=0.
REQ-027 Reset asserted in CALC or FIX SHALL abort the operation with no Done pulse; HI and LO SHALL read 0 after reset.
REQ-028 After reset_n rises, the first Start SHALL be accepted normally.

Verification
REQ-029 A=100, B=7, Start pulse -> Done at E33+: LO=0x0000000E, HI=0x00000002; Busy high E0..E33.
REQ-030 A=-100 (0xFFFFFF9C), B=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2); A=100, B=-7 -> LO=0xFFFFFFF2, HI=0x00000002.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, DivZero=0.
REQ-032 Preload HI/LO from a prior op; A=5, B=0, Start -> DivZero high exactly one cycle, Busy=0, Done never, HI/LO unchanged.
REQ-033 A=100, B=7, Start; after 10 CALC cycles pulse reset_n low -> HI=LO=0, Busy=0, no Done; then A=9, B=2 -> LO=4, HI=1.
REQ-034 Start held high with new operands during CALC -> result reflects only the E0 operands; a second Start on the cycle after Done -> second result after 33 further edges.

Source files
------------

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
// Handshake and data bundle between a requester and the signed divider.
//   Start   : request pulse from the requester (sampled only while idle)
//   A, B    : signed 32-bit dividend / divisor
//   HI, LO  : remainder / quotient registers (feed the register-file write mux)
//   Busy    : division in progress
//   Done    : one-cycle completion pulse
//   DivZero : one-cycle pulse when a request arrives with B == 0
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_unit_if;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    modport master (
        output Start, A, B,
        input  HI, LO, Busy, Done, DivZero
    );

    modport slave (
        input  Start, A, B,
        output HI, LO, Busy, Done, DivZero
    );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Fixed-latency 32-bit signed divider. Magnitudes are divided with a restoring
// shift-subtract loop, one quotient bit per cycle; signs are applied at the end.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : div_unit_if.slave (Start, A, B in; HI, LO, Busy, Done, DivZero out)
// Timing: Start accepted at edge E0, iterations on E1..E32, result written to
// HI/LO at E33 with Done high for the following cycle.
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        reset_n,
    div_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] quo_q;     // dividend bits shift out MSB-first, quotient bits shift in
    logic [31:0] div_q;     // |B|
    logic [31:0] rem_q;     // partial remainder, always < |B| between iterations
    logic [4:0]  cnt_q;
    logic        neg_rem_q; // sign(A)
    logic        neg_quo_q; // sign(A) xor sign(B)
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        divzero_q;

    // Operand magnitudes at the request; 0x80000000 maps to itself, which is
    // the correct unsigned magnitude.
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    assign a_mag = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    assign b_mag = bus.B[31] ? (32'd0 - bus.B) : bus.B;

    // One restoring iteration on a 33-bit working remainder.
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        q_bit;
    logic [31:0] rem_d;
    logic [31:0] quo_d;

    // NOTE: every signal driven here gets a value on every path, so no latch
    // is inferred.
    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        rem_diff  = rem_shift - {1'b0, div_q};
        q_bit     = ~rem_diff[32];
        rem_d     = q_bit ? rem_diff[31:0] : rem_shift[31:0];
        quo_d     = {quo_q[30:0], q_bit};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            quo_q     <= '0;
            div_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            // Pulse outputs default low; set only on the edge that raises them.
            done_q    <= 1'b0;
            divzero_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        if (bus.B == 32'd0) begin
                            divzero_q <= 1'b1;
                        end else begin
                            quo_q     <= a_mag;
                            div_q     <= b_mag;
                            rem_q     <= '0;
                            cnt_q     <= 5'd31;
                            neg_rem_q <= bus.A[31];
                            neg_quo_q <= bus.A[31] ^ bus.B[31];
                            busy_q    <= 1'b1;
                            state_q   <= CALC;
                        end
                    end
                end

                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_q <= FIX;
                    end
                end

                FIX: begin
                    lo_q    <= neg_quo_q ? (32'd0 - quo_q) : quo_q;
                    hi_q    <= neg_rem_q ? (32'd0 - rem_q) : rem_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.DivZero = divzero_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed self-checking bench for div_unit. Inputs are driven just after the
// falling edge or 1 time unit after the rising edge; outputs are sampled 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic clk;
    logic reset_n;

    div_unit_if bus ();

    div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Background monitors: pulse counts and Done/DivZero overlap.
    int done_cnt    = 0;
    int divzero_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.Done)                done_cnt++;
            if (bus.DivZero)             divzero_cnt++;
            if (bus.Done && bus.DivZero) overlap_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Present operands with Start high so that the next rising edge is E0.
    task automatic present(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
    endtask

    // Full operation: Start pulse, operands scrambled after E0, result expected
    // exactly after E33 with Busy high from E0 through E32.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int bad;
        bad = 0;
        present(a, b);
        @(posedge clk); #1;                          // E0
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        check({tag, "_busy_e0"}, {31'd0, bus.Busy}, 32'd1);
        repeat (32) begin                            // E1..E32
            @(posedge clk); #1;
            if (bus.Done || !bus.Busy) bad++;
        end
        check({tag, "_busy_window"}, bad, 32'd0);
        @(posedge clk); #1;                          // E33
        check({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
        check({tag, "_busy_fall"}, {31'd0, bus.Busy}, 32'd0);
        check({tag, "_lo"}, bus.LO, exp_lo);
        check({tag, "_hi"}, bus.HI, exp_hi);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, bus.Done}, 32'd0);
    endtask

    initial begin
        int d0;
        int bad;

        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        reset_n   = 1'b0;
        #1;
        // Asynchronous reset values before any clock edge.
        check("rst_hi",      bus.HI, 32'd0);
        check("rst_lo",      bus.LO, 32'd0);
        check("rst_busy",    {31'd0, bus.Busy},    32'd0);
        check("rst_done",    {31'd0, bus.Done},    32'd0);
        check("rst_divzero", {31'd0, bus.DivZero}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Sign combinations and boundary operands.
        run_div("p100_p7",   32'd100,        32'd7,          32'h0000000E, 32'h00000002);
        run_div("n100_p7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE);
        run_div("p100_n7",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2, 32'h00000002);
        run_div("n100_n7",   32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE);
        run_div("min_neg1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000);
        run_div("small_big", 32'd7,          32'd100,        32'h00000000, 32'h00000007);
        run_div("max_min",   32'h7FFFFFFF,   32'h80000000,   32'h00000000, 32'h7FFFFFFF);
        run_div("neg1_p1",   32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000);
        check("no_divzero_yet", divzero_cnt, 32'd0);

        // Divide by zero: HI/LO keep the last result (from neg1_p1).
        present(32'd5, 32'd0);
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check("dz_pulse",  {31'd0, bus.DivZero}, 32'd1);
        check("dz_busy",   {31'd0, bus.Busy},    32'd0);
        check("dz_done",   {31'd0, bus.Done},    32'd0);
        d0 = done_cnt;
        @(posedge clk); #1;
        check("dz_one_cycle", {31'd0, bus.DivZero}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("dz_no_done", done_cnt - d0, 32'd0);
        check("dz_hi_keep", bus.HI, 32'h00000000);
        check("dz_lo_keep", bus.LO, 32'hFFFFFFFF);
        check("dz_busy_after", {31'd0, bus.Busy}, 32'd0);

        // Reset in the middle of CALC aborts with no Done and clears HI/LO.
        run_div("pre_rst", 32'd100, 32'd7, 32'h0000000E, 32'h00000002);
        present(32'd100, 32'd7);
        @(posedge clk); #1;                          // E0
        bus.Start = 1'b0;
        repeat (10) @(posedge clk);
        d0 = done_cnt;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_hi",   bus.HI, 32'd0);
        check("abort_lo",   bus.LO, 32'd0);
        check("abort_busy", {31'd0, bus.Busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_idle_busy", {31'd0, bus.Busy}, 32'd0);
        run_div("after_rst", 32'd9, 32'd2, 32'h00000004, 32'h00000001);

        // Start held high with changing operands, then back-to-back request.
        present(32'd100, 32'd7);
        @(posedge clk); #1;                          // E0 of first op
        bus.A = 32'd1000;
        bus.B = 32'd3;                               // Start stays high
        bad = 0;
        repeat (32) begin
            @(posedge clk); #1;
            if (!bus.Busy || bus.Done) bad++;
        end
        check("hold_busy_window", bad, 32'd0);
        @(posedge clk); #1;                          // E33 of first op
        check("hold_done", {31'd0, bus.Done}, 32'd1);
        check("hold_lo",   bus.LO, 32'h0000000E);
        check("hold_hi",   bus.HI, 32'h00000002);
        bus.A = 32'd50;
        bus.B = 32'hFFFFFFFA;                        // -6
        @(posedge clk); #1;                          // E0 of second op
        bus.Start = 1'b0;
        bus.A     = 32'd77;
        bus.B     = 32'd0;
        check("b2b_busy", {31'd0, bus.Busy}, 32'd1);
        check("b2b_no_dz", {31'd0, bus.DivZero}, 32'd0);
        repeat (32) @(posedge clk);
        #1;
        check("b2b_not_yet", {31'd0, bus.Done}, 32'd0);
        @(posedge clk); #1;                          // E33 of second op
        check("b2b_done", {31'd0, bus.Done}, 32'd1);
        check("b2b_lo",   bus.LO, 32'hFFFFFFF8);
        check("b2b_hi",   bus.HI, 32'h00000002);

        repeat (3) @(posedge clk);
        #1;
        check("divzero_total", divzero_cnt, 32'd1);
        check("done_dz_overlap", overlap_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
